// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder. Defining SERIAL_ADDER_OVF_EN
// adds the registered signed-overflow flag ovf.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, carry, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, carry, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, carry);
    modport slave  (input start, a, b, cin, output busy, done, sum, carry);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus carry flop, LSB first, WIDTH
// cycles per add. SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic {IDLE, ADD} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, shreg, shreg_nxt, sum_q;
    logic [CW-1:0]    cnt;
    logic             c, c_nxt, s_bit, last;
    logic             carry_q, done_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    always_comb begin
        state_nxt = state;
        last      = 1'b0;
        // Operands shift right each cycle, so bit `cnt` is always at index 0.
        s_bit     = opa[0] ^ opb[0] ^ c;
        c_nxt     = (opa[0] & opb[0]) | (c & (opa[0] ^ opb[0]));
        shreg_nxt = (shreg >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
        case (state)
            IDLE: if (bus.start) state_nxt = ADD;
            ADD: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa     <= '0;
            opb     <= '0;
            c       <= 1'b0;
            shreg   <= '0;
            cnt     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= last;
            if (state == IDLE) begin
                if (bus.start) begin
                    opa <= bus.a;
                    opb <= bus.b;
                    c   <= bus.cin;
                    cnt <= '0;
                end
            end else begin
                opa   <= opa >> 1;
                opb   <= opb >> 1;
                c     <= c_nxt;
                shreg <= shreg_nxt;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    sum_q   <= shreg_nxt;
                    carry_q <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                    // c is the carry into the MSB on the final bit.
                    ovf_q   <= c ^ c_nxt;
`endif
                end
            end
        end
    end

    assign bus.busy  = (state == ADD);
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1 with directed vectors.
module tb_serial_adder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8();
    serial_adder_if #(.WIDTH(1)) if1();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the 8-bit instance
    exp_t last8 = '{8'h00, 1'b0, 1'b0};
    int   bcnt8 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last8 = '{8'h00, 1'b0, 1'b0};
            bcnt8 = 0;
        end else begin
            if (if8.busy) bcnt8++;
            if (if8.done) begin
                if (q8.size() == 0) chk("unexpected_done8", 1, 0);
                else begin
                    e = q8.pop_front();
                    chk("sum8", if8.sum, e.s);
                    chk("carry8", if8.carry, e.c);
`ifdef SERIAL_ADDER_OVF_EN
                    chk("ovf8", if8.ovf, e.o);
`endif
                    chk("latency8", bcnt8, 8);
                    last8 = e;
                end
                bcnt8 = 0;
            end else begin
                chk("hold_sum8", if8.sum, last8.s);
                chk("hold_carry8", if8.carry, last8.c);
            end
        end
    end

    // Monitor for the 1-bit instance
    exp_t last1 = '{8'h00, 1'b0, 1'b0};
    int   bcnt1 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last1 = '{8'h00, 1'b0, 1'b0};
            bcnt1 = 0;
        end else begin
            if (if1.busy) bcnt1++;
            if (if1.done) begin
                if (q1.size() == 0) chk("unexpected_done1", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("sum1", if1.sum, e.s[0]);
                    chk("carry1", if1.carry, e.c);
`ifdef SERIAL_ADDER_OVF_EN
                    chk("ovf1", if1.ovf, e.o);
`endif
                    chk("latency1", bcnt1, 1);
                    last1 = e;
                end
                bcnt1 = 0;
            end else begin
                chk("hold_sum1", if1.sum, last1.s[0]);
                chk("hold_carry1", if1.carry, last1.c);
            end
        end
    end

    task automatic wait_idle8();
        int n = 0;
        while (if8.busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (if8.busy) chk("idle_timeout8", 1, 0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input exp_t e);
        wait_idle8();
        if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = cin;
        q8.push_back(e);
        @(posedge clk); #1;
        if8.start = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (q8.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain8", q8.size(), 0);
        #1;
    endtask

    task automatic drain1();
        int n = 0;
        while (q1.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain1", q1.size(), 0);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst_busy8", if8.busy, 0);
        chk("rst_done8", if8.done, 0);
        chk("rst_sum8", if8.sum, 0);
        chk("rst_carry8", if8.carry, 0);
        chk("rst_busy1", if1.busy, 0);
        chk("rst_done1", if1.done, 0);
        chk("rst_sum1", if1.sum, 0);
        chk("rst_carry1", if1.carry, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf8", if8.ovf, 0);
        chk("rst_ovf1", if1.ovf, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        #12;
        chk_reset_state();
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        op8(8'h00, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b0});
        op8(8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0});
        op8(8'hA5, 8'h5A, 1'b1, '{8'h00, 1'b1, 1'b0});
        op8(8'hFF, 8'hFF, 1'b1, '{8'hFF, 1'b1, 1'b0});
        op8(8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1});
        op8(8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0});

        // Start pulsed mid-operation must be ignored
        op8(8'h12, 8'h34, 1'b0, '{8'h46, 1'b0, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        drain8();
        repeat (12) @(posedge clk);
        #1;

        // Reset in the middle of an operation
        wait_idle8();
        if8.start = 1'b1; if8.a = 8'h80; if8.b = 8'h80; if8.cin = 1'b0;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_state();
        #10 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("idle_after_reset8", if8.busy, 0);
        op8(8'h01, 8'h02, 1'b0, '{8'h03, 1'b0, 1'b0});
        drain8();

        // WIDTH=1 back-to-back: second start lands in the done cycle
        if1.start = 1'b1; if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1;
        q1.push_back('{8'h01, 1'b1, 1'b0});
        @(posedge clk); #1;
        if1.start = 1'b0;
        @(posedge clk); #1;
        chk("done_cycle1", if1.done, 1);
        if1.start = 1'b1; if1.a = 1'b0; if1.b = 1'b1; if1.cin = 1'b0;
        q1.push_back('{8'h01, 1'b0, 1'b0});
        @(posedge clk); #1;
        if1.start = 1'b0;
        chk("b2b_accept1", if1.busy, 1);
        drain1();
        repeat (5) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder; the multi-cycle successor of the single-bit half adder.
- Adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first, using one full-adder cell and a carry flip-flop.
- Uses a start/busy/done handshake and holds its result registers until the next operation completes.
- Used where area matters more than latency, e.g. slow datapath accumulation and checksum stages.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the edge that accepts start
- b  input  WIDTH  operand B; captured on the edge that accepts start
- cin  input  1  carry-in; captured with a/b
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when sum/carry update
- sum  output  WIDTH  registered result, a + b + cin modulo 2^WIDTH
- carry  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Reset: one clock, asynchronous, active-low (rst_n low clears immediately, independent of clk). Reset values:
  - state IDLE; busy=0, done=0, sum=0, carry=0
  - internal operand, shift, count and carry registers all 0
- States:
  - IDLE: start=1 at edge E0 latches a, b, cin, clears bit counter, moves to ADD; busy=1 from E0.
  - ADD: edges E1..E_WIDTH each process bit i = count:
    - s_i = a_i ^ b_i ^ c
    - c' = (a_i & b_i) | (c & (a_i ^ b_i))
    - s_i shifts into internal shift register from MSB side; counter increments.
  - At edge E_WIDTH: shift result copies to sum, final carry to carry, done=1 for exactly one cycle, busy=0, state returns to IDLE.
- Latency:
  - done is visible in the cycle after E_WIDTH, i.e. WIDTH cycles after start is accepted.
  - Throughput is one operation per WIDTH+1 cycles.
- Result hold: sum/carry change only at completion edges; they hold the previous result during busy and in IDLE.
- start while busy=1 is ignored (no queueing); a/b/cin changes during ADD have no effect.
- Back-to-back: start high during the done cycle (state IDLE) is accepted at the next edge.
- WIDTH=1: single ADD cycle; done one cycle after start.
- Counter width is clog2(WIDTH+1), minimum 1 bit; counter never wraps within an operation.
- Reset mid-operation: operation abandoned, all outputs return to reset values, no done pulse. After release, IDLE waits for a fresh start.
- cin=1 with a=b=all-ones gives sum=all-ones, carry=1.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - extra output port ovf (1 bit) = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (two's-complement signed overflow).
  - ovf is registered and updated on the same edge as sum/carry; reset value 0; held until the next completion.
- Undefined: no ovf port, no internal logic for it.

Test Plan:
- WIDTH=8: a=0x00, b=0x00, cin=0, start pulse -> busy 8 cycles, done pulse, sum=0x00, carry=0.
- WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1; a=0xA5, b=0x5A, cin=1 -> sum=0x00, carry=1.
- Hold and ignore: 0x12+0x34 started; start with 0xFF+0xFF pulsed mid-op -> second start ignored, sum=0x46, carry=0. sum shows the prior result until done; no second done pulse.
- Reset mid-op: 0x80+0x80 started, rst_n low at cycle 4 -> busy=0, done=0, sum=0x00, carry=0 immediately; no done after release.
- Back-to-back, WIDTH=1: a=1, b=1, cin=1 -> sum=1, carry=1. New start during done cycle with a=0, b=1, cin=0 -> accepted, sum=1, carry=0.
- SERIAL_ADDER_OVF_EN, WIDTH=8:
  - 0x7F+0x01 -> sum=0x80, carry=0, ovf=1
  - 0xFF+0x01 -> sum=0x00, carry=1, ovf=0
